key_event_fifo: RTL and testbench

- Buffers decoded key events between the keyboard decoder and the processor's input port.
- Each one-cycle key_pressed strobe carries a translated keycode (0..100). The block queues that code in a small first-word-fall-through FIFO.
- The processor drains the FIFO at its own pace with a read strobe, so no keystroke is lost while the core is busy.
- Flags overflow and filters out-of-range codes.

---
 rtl/key_event_fifo_if.sv | 29 ++
 rtl/key_event_fifo.sv | 86 ++++++++
 tb/tb_key_event_fifo.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/key_event_fifo_if.sv
// Key event FIFO bus: decoder-side strobe, processor-side read port and status.
// Handshake: a keycode is offered when key_pressed=1 (one cycle, no backpressure);
// the head entry is consumed on a rising edge where rd_en=1 and rd_valid=1.
interface key_event_fifo_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
);
  logic                     key_pressed;
  logic [WIDTH-1:0]         keycode;
  logic                     rd_en;
  logic                     clear_overflow;
  logic [WIDTH-1:0]         rd_data;
  logic                     rd_valid;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic                     overflow;

  // Producer / processor side
  modport master (
    output key_pressed, keycode, rd_en, clear_overflow,
    input  rd_data, rd_valid, count, full, overflow
  );

  // FIFO side
  modport slave (
    input  key_pressed, keycode, rd_en, clear_overflow,
    output rd_data, rd_valid, count, full, overflow
  );
endinterface

// File: rtl/key_event_fifo.sv
// First-word-fall-through queue of decoded keycodes between the keyboard
// decoder and the processor. Out-of-range codes are discarded; strobes that
// arrive while full are dropped and flagged in a sticky overflow bit.
module key_event_fifo #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 8,
  parameter int MAX_CODE = 100
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  key_event_fifo_if.slave     bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;

  logic wr_ok, pop, do_write, drop, is_full;

  // Next-state: accept/pop decisions, pointers, count and the registered head
  always_comb begin
    is_full  = (count_q == CNT_W'(DEPTH));
    wr_ok    = bus.key_pressed && (bus.keycode <= WIDTH'(MAX_CODE));
    pop      = bus.rd_en && rd_valid_q;
    do_write = wr_ok && (!is_full || pop);
    drop     = wr_ok && is_full && !pop;

    wr_ptr_d = do_write ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop      ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    if (do_write && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !do_write) count_d = count_q - CNT_W'(1);

    // The new head is the incoming code when it lands in the head slot
    // (write into empty, or write+pop with one entry); otherwise it is
    // already in storage.
    rd_valid_d = (count_d != '0);
    rd_data_d  = '0;
    if (rd_valid_d) begin
      if (do_write && (rd_ptr_d == wr_ptr_q)) rd_data_d = bus.keycode;
      else                                    rd_data_d = mem_q[rd_ptr_d];
    end

    // Set wins over clear
    overflow_d = overflow_q;
    if (drop)                    overflow_d = 1'b1;
    else if (bus.clear_overflow) overflow_d = 1'b0;
  end

  // Control and output registers, cleared asynchronously
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents need no reset
  always_ff @(posedge CLOCK_50) begin
    if (do_write) mem_q[wr_ptr_q] <= bus.keycode;
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.count    = count_q;
  assign bus.full     = is_full;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_key_event_fifo.sv
// Directed bench for key_event_fifo (DEPTH=8, WIDTH=8, MAX_CODE=100).
module tb_key_event_fifo;
  localparam int DEPTH = 8;
  localparam int WIDTH = 8;

  logic CLOCK_50;
  logic resetn;
  int   total;
  int   bad;

  key_event_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  key_event_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MAX_CODE(100)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .bus      (bus.slave)
  );

  // Clock and reset
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // One cycle: inputs set after this return are seen at the next edge
  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] c);
    bus.key_pressed = 1'b1;
    bus.keycode     = c;
    step();
    bus.key_pressed = 1'b0;
  endtask

  task automatic pop_one();
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.key_pressed = 1'b0; bus.keycode = '0; bus.rd_en = 1'b0; bus.clear_overflow = 1'b0;
    #3;
    total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.rd_valid); end
    total++; if (bus.rd_data !== 8'd0) begin bad++; $display("FAIL reset_data got=%0d exp=0", bus.rd_data); end
    total++; if (bus.full !== 1'b0 || bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", bus.full, bus.overflow); end
    step(); step();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_basic();
    push(8'd5);
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'd5) begin bad++; $display("FAIL basic_first got=%b/%0d exp=1/5", bus.rd_valid, bus.rd_data); end
    push(8'd99);
    push(8'd100);
    total++; if (bus.count !== 4'd3) begin bad++; $display("FAIL basic_count got=%0d exp=3", bus.count); end
    total++; if (bus.rd_data !== 8'd5) begin bad++; $display("FAIL basic_pop0 got=%0d exp=5", bus.rd_data); end
    pop_one();
    total++; if (bus.rd_data !== 8'd99) begin bad++; $display("FAIL basic_pop1 got=%0d exp=99", bus.rd_data); end
    pop_one();
    total++; if (bus.rd_data !== 8'd100) begin bad++; $display("FAIL basic_pop2 got=%0d exp=100", bus.rd_data); end
    pop_one();
    total++; if (bus.rd_valid !== 1'b0 || bus.count !== 4'd0) begin bad++; $display("FAIL basic_empty got=%b/%0d exp=0/0", bus.rd_valid, bus.count); end
  endtask

  task automatic test_filter();
    push(8'd101);
    push(8'd255);
    total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL filter_count got=%0d exp=0", bus.count); end
    total++; if (bus.rd_valid !== 1'b0 || bus.overflow !== 1'b0) begin bad++; $display("FAIL filter_flags got=%b/%b exp=0/0", bus.rd_valid, bus.overflow); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) push(8'(i));
    total++; if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_full got=%b/%b exp=1/0", bus.full, bus.overflow); end
    push(8'd8);
    total++; if (bus.overflow !== 1'b1 || bus.count !== 4'd8) begin bad++; $display("FAIL ovf_drop got=%b/%0d exp=1/8", bus.overflow, bus.count); end
    // Another drop with clear in the same cycle: set wins
    bus.clear_overflow = 1'b1;
    push(8'd50);
    bus.clear_overflow = 1'b0;
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b exp=1", bus.overflow); end
    for (int i = 0; i < 8; i++) begin
      total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'(i)) begin bad++; $display("FAIL ovf_drain%0d got=%b/%0d exp=1/%0d", i, bus.rd_valid, bus.rd_data, i); end
      pop_one();
    end
    total++; if (bus.rd_valid !== 1'b0 || bus.count !== 4'd0) begin bad++; $display("FAIL ovf_empty got=%b/%0d exp=0/0", bus.rd_valid, bus.count); end
    bus.clear_overflow = 1'b1;
    step();
    bus.clear_overflow = 1'b0;
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", bus.overflow); end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 8; i++) push(8'(10 + i));
    bus.key_pressed = 1'b1; bus.keycode = 8'd42; bus.rd_en = 1'b1;
    step();
    bus.key_pressed = 1'b0; bus.rd_en = 1'b0;
    total++; if (bus.count !== 4'd8 || bus.full !== 1'b1) begin bad++; $display("FAIL fsim_count got=%0d/%b exp=8/1", bus.count, bus.full); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL fsim_ovf got=%b exp=0", bus.overflow); end
    for (int i = 0; i < 8; i++) begin
      logic [WIDTH-1:0] exp_v;
      exp_v = (i == 7) ? 8'd42 : 8'(11 + i);
      total++; if (bus.rd_data !== exp_v) begin bad++; $display("FAIL fsim_drain%0d got=%0d exp=%0d", i, bus.rd_data, exp_v); end
      pop_one();
    end
    total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL fsim_empty got=%0d exp=0", bus.count); end
  endtask

  task automatic test_count_one();
    push(8'd7);
    bus.key_pressed = 1'b1; bus.keycode = 8'd3; bus.rd_en = 1'b1;
    step();
    bus.key_pressed = 1'b0; bus.rd_en = 1'b0;
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'd3 || bus.count !== 4'd1) begin bad++; $display("FAIL one_simul got=%b/%0d/%0d exp=1/3/1", bus.rd_valid, bus.rd_data, bus.count); end
    pop_one();
    pop_one();  // read while empty
    total++; if (bus.count !== 4'd0 || bus.rd_valid !== 1'b0) begin bad++; $display("FAIL one_rd_empty got=%0d/%b exp=0/0", bus.count, bus.rd_valid); end
    push(8'd20);
    push(8'd21);
    total++; if (bus.rd_data !== 8'd20 || bus.count !== 4'd2) begin bad++; $display("FAIL one_after got=%0d/%0d exp=20/2", bus.rd_data, bus.count); end
    pop_one();
    total++; if (bus.rd_data !== 8'd21) begin bad++; $display("FAIL one_next got=%0d exp=21", bus.rd_data); end
    pop_one();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) push(8'(30 + i));
    #2;
    resetn = 1'b0;
    #1;
    total++; if (bus.count !== 4'd0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 8'd0) begin bad++; $display("FAIL rmid_async got=%0d/%b/%0d exp=0/0/0", bus.count, bus.rd_valid, bus.rd_data); end
    step();
    resetn = 1'b1;
    step();
    push(8'd12);
    total++; if (bus.rd_data !== 8'd12 || bus.count !== 4'd1) begin bad++; $display("FAIL rmid_after got=%0d/%0d exp=12/1", bus.rd_data, bus.count); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_filter();
    test_overflow();
    test_full_simul();
    test_count_one();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
